// File: rtl/and_gate_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : and_check_pkg                                                    |
// | Purpose : Shared types and helpers for the AND-gate stimulus/checker.      |
// |           FSM state encoding, settle-counter width and the reduction-AND   |
// |           reference used to form the expected DUT response.                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package and_check_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } chk_state_t;

  localparam int SETTLE_W = 4;

  // AND of the low i_n bits of i_vec (i_n in 1..8); bits above i_n are ignored.
  function automatic logic reduce_and(input logic [7:0] i_vec, input int i_n);
    logic w_res;
    w_res = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < i_n) begin
        w_res = w_res & i_vec[i];
      end
    end
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/and_gate_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : and_gate_checker_if                                            |
// | Purpose   : Bundles the run-control, stimulus/response and result signals  |
// |             between the checker and the bench/DUT side.                    |
// | Ports     : start, resp            -> checker                              |
// |             stim, busy, done, pass, err_count, first_fail_vld,             |
// |             first_fail_vec         <- checker                              |
// |             master = checker side, slave = bench / DUT side                |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface and_gate_checker_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic [N_IN-1:0] stim;
  logic            resp;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            first_fail_vld;
  logic [N_IN-1:0] first_fail_vec;

  modport master (
    input  start,
    input  resp,
    output stim,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail_vld,
    output first_fail_vec
  );

  modport slave (
    output start,
    output resp,
    input  stim,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail_vld,
    input  first_fail_vec
  );

endinterface
`default_nettype wire

// File: rtl/and_gate_checker_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : settle_timer                                                     |
// | Purpose : Down-counter timing the settle interval between driving a        |
// |           vector and sampling the DUT response.                            |
// | Ports   : clk, rst     clock / synchronous active-high reset               |
// |           i_load       load i_load_val (priority over decrement)           |
// |           i_load_val   settle cycle count                                  |
// |           i_dec        decrement by one (holds at zero)                    |
// |           o_last       the decrement happening this cycle reaches zero     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module settle_timer #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_load,
  input  wire logic [W-1:0] i_load_val,
  input  wire logic         i_dec,
  output logic              o_last
);

  localparam logic [W-1:0] c_ONE = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

  // A count of zero also reads as "last" so a caller can never stall here.
  assign o_last = (r_cnt <= c_ONE);

endmodule
`default_nettype wire

// File: rtl/and_gate_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : and_gate_checker                                                 |
// | Purpose : Exhaustive stimulus generator and response checker for an       |
// |           N_IN-input AND gate. Walks vectors 0..2**N_IN-1, waits           |
// |           SETTLE_CYCLES after each drive, compares resp with &stim and     |
// |           reports pass, error count and the first failing vector.          |
// | Ports   : clk   clock, rising edge                                         |
// |           rst   synchronous reset, active-high                             |
// |           bus   and_gate_checker_if.master (start/resp in; stim, busy,     |
// |                 done, pass, err_count, first_fail_vld/vec out)             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module and_gate_checker
  import and_check_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input wire logic                clk,
  input wire logic                rst,
  and_gate_checker_if.master      bus
);

  localparam logic [N_IN-1:0]     c_VEC_LAST = '1;
  localparam logic [N_IN-1:0]     c_VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]       c_ERR_MAX  = {1'b1, {N_IN{1'b0}}};
  localparam logic [SETTLE_W-1:0] c_SETTLE   = SETTLE_W'(SETTLE_CYCLES);

  chk_state_t      r_state;
  chk_state_t      w_state_nxt;

  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] r_stim;
  logic [N_IN:0]   r_err;
  logic            r_ff_vld;
  logic [N_IN-1:0] r_ff_vec;
  logic            r_pass;

  logic            w_tmr_last;
  logic            w_exp;
  logic            w_mismatch;
  logic            w_err_inc;
  logic [N_IN:0]   w_err_nxt;
  logic            w_last_vec;

  settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == DRIVE),
    .i_load_val (c_SETTLE),
    .i_dec      (r_state == SETTLE),
    .o_last     (w_tmr_last)
  );

  // Expected value is formed from the registered stim, i.e. exactly what the
  // DUT is currently seeing.
  assign w_exp      = reduce_and(8'(r_stim), N_IN);
  assign w_mismatch = (r_state == CHECK) && (bus.resp != w_exp);
  assign w_err_inc  = w_mismatch && (r_err != c_ERR_MAX);
  assign w_err_nxt  = r_err + {{N_IN{1'b0}}, w_err_inc};
  assign w_last_vec = (r_vec == c_VEC_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        w_state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (w_tmr_last) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_state_nxt = w_last_vec ? DONE : DRIVE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Vector counter, stimulus and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec    <= '0;
      r_stim   <= '0;
      r_err    <= '0;
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // Starting a run clears the previous results; stim keeps the last vector.
          if (bus.start) begin
            r_vec    <= '0;
            r_err    <= '0;
            r_ff_vld <= 1'b0;
            r_ff_vec <= '0;
            r_pass   <= 1'b0;
          end
        end
        DRIVE: begin
          r_stim <= r_vec;
        end
        CHECK: begin
          r_err <= w_err_nxt;
          if (w_mismatch && !r_ff_vld) begin
            r_ff_vld <= 1'b1;
            r_ff_vec <= r_stim;
          end
          if (w_last_vec) begin
            r_pass <= (w_err_nxt == '0);
          end else begin
            r_vec <= r_vec + c_VEC_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stim           = r_stim;
  assign bus.busy           = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == CHECK);
  assign bus.done           = (r_state == DONE);
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_err;
  assign bus.first_fail_vld = r_ff_vld;
  assign bus.first_fail_vec = r_ff_vec;

endmodule
`default_nettype wire

// File: tb/tb_and_gate_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_and_gate_checker                                              |
// | Purpose : Self-checking bench for and_gate_checker. Two instances:         |
// |           A (N_IN=2, SETTLE_CYCLES=1) and B (N_IN=3, SETTLE_CYCLES=0),     |
// |           each looped back through a behavioural AND gate that can be      |
// |           made correct, stuck-at-0 or stuck-at-1.                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_and_gate_checker;

  typedef struct {
    logic [8:0] err;
    logic       pass;
    logic       vld;
    logic [7:0] vec;
  } res_t;

  logic clk;
  logic rst;
  int   mode_a;
  int   mode_b;
  int   n_pass;
  int   n_total;

  logic [7:0] q_stim[$];
  res_t       q_res[$];

  and_gate_checker_if #(.N_IN(2)) bus_a ();
  and_gate_checker_if #(.N_IN(3)) bus_b ();

  and_gate_checker #(.N_IN(2), .SETTLE_CYCLES(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  and_gate_checker #(.N_IN(3), .SETTLE_CYCLES(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Gate under test: 0 = correct AND, 1 = stuck-at-0, 2 = stuck-at-1
  assign bus_a.resp = (mode_a == 0) ? (bus_a.stim == 2'b11) : (mode_a == 2);
  assign bus_b.resp = (mode_b == 0) ? (bus_b.stim == 3'b111) : (mode_b == 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected end-of-run results for an n-input gate in the given mode.
  function automatic res_t model_run(input int n, input int mode);
    res_t r;
    logic e;
    logic g;
    r.err  = '0;
    r.pass = 1'b0;
    r.vld  = 1'b0;
    r.vec  = '0;
    for (int v = 0; v < (1 << n); v++) begin
      e = (v == ((1 << n) - 1));
      g = (mode == 0) ? e : (mode == 2);
      if (g != e) begin
        if (!r.vld) begin
          r.vld = 1'b1;
          r.vec = v[7:0];
        end
        r.err = r.err + 9'd1;
      end
    end
    r.pass = (r.err == 9'd0);
    return r;
  endfunction

  // Raise start for one edge; returns at the negedge after the accepting edge.
  task automatic pulse_start_a();
    @(negedge clk) bus_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bus_a.start = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk) bus_b.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bus_b.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
         bus_a.first_fail_vld, bus_a.first_fail_vec} !== 11'd0)
      $display("FAIL reset_a: got stim=%0h busy=%0b done=%0b pass=%0b err=%0d vld=%0b vec=%0h, want all 0",
               bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
               bus_a.first_fail_vld, bus_a.first_fail_vec);
    else n_pass++;
    n_total++;
    if ({bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count,
         bus_b.first_fail_vld, bus_b.first_fail_vec} !== 14'd0)
      $display("FAIL reset_b: got busy=%0b done=%0b err=%0d, want all 0",
               bus_b.busy, bus_b.done, bus_b.err_count);
    else n_pass++;
    rst = 1'b0;
    bus_a.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0)
      $display("FAIL reset_idle: got busy=%0b done=%0b, want 0 0", bus_a.busy, bus_a.done);
    else n_pass++;
  endtask

  task automatic test_run_modes();
    logic [7:0] ev;
    res_t       er;
    for (int m = 0; m < 3; m++) begin
      mode_a = m;
      for (int k = 0; k < 4; k++) q_stim.push_back(k[7:0]);
      q_res.push_back(model_run(2, m));
      pulse_start_a();
      for (int e = 1; e <= 12; e++) begin
        @(posedge clk);
        @(negedge clk);
        if (e % 3 == 2) begin
          ev = q_stim.pop_front();
          n_total++;
          if (bus_a.stim !== ev[1:0] || bus_a.busy !== 1'b1)
            $display("FAIL run_stim mode=%0d edge=%0d: got stim=%0h busy=%0b, want stim=%0h busy=1",
                     m, e, bus_a.stim, bus_a.busy, ev[1:0]);
          else n_pass++;
        end
        if (e == 11) begin
          n_total++;
          if (bus_a.done !== 1'b0)
            $display("FAIL run_early_done mode=%0d: got done=%0b, want 0", m, bus_a.done);
          else n_pass++;
        end
      end
      er = q_res.pop_front();
      n_total++;
      if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.pass !== er.pass ||
          bus_a.err_count !== er.err[2:0] || bus_a.first_fail_vld !== er.vld ||
          bus_a.first_fail_vec !== er.vec[1:0])
        $display("FAIL run_result mode=%0d: got done=%0b busy=%0b pass=%0b err=%0d vld=%0b vec=%0h, want done=1 busy=0 pass=%0b err=%0d vld=%0b vec=%0h",
                 m, bus_a.done, bus_a.busy, bus_a.pass, bus_a.err_count, bus_a.first_fail_vld,
                 bus_a.first_fail_vec, er.pass, er.err, er.vld, er.vec[1:0]);
      else n_pass++;
      // Results must hold while DONE persists.
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (bus_a.done !== 1'b1 || bus_a.err_count !== er.err[2:0] || bus_a.pass !== er.pass)
        $display("FAIL run_hold mode=%0d: got done=%0b err=%0d pass=%0b, want 1 %0d %0b",
                 m, bus_a.done, bus_a.err_count, bus_a.pass, er.err, er.pass);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    mode_a = 0;
    pulse_start_a();
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus_a.stim !== 2'b10 || bus_a.busy !== 1'b1)
      $display("FAIL mid_pre: got stim=%0h busy=%0b, want 2 1", bus_a.stim, bus_a.busy);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
         bus_a.first_fail_vld, bus_a.first_fail_vec} !== 11'd0)
      $display("FAIL mid_reset: got stim=%0h busy=%0b done=%0b err=%0d, want all 0",
               bus_a.stim, bus_a.busy, bus_a.done, bus_a.err_count);
    else n_pass++;
    pulse_start_a();
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b1)
      $display("FAIL mid_rerun_11: got done=%0b busy=%0b, want 0 1", bus_a.done, bus_a.busy);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b1 || bus_a.err_count !== 3'd0)
      $display("FAIL mid_rerun_12: got done=%0b pass=%0b err=%0d, want 1 1 0",
               bus_a.done, bus_a.pass, bus_a.err_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    mode_a = 0;
    pulse_start_a();
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 4) bus_a.start = 1'b1;
      if (e == 5) bus_a.start = 1'b0;
      if (e == 11) begin
        n_total++;
        if (bus_a.done !== 1'b0)
          $display("FAIL b2b_early_done: got done=%0b, want 0", bus_a.done);
        else n_pass++;
      end
    end
    n_total++;
    if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b1 || bus_a.err_count !== 3'd0)
      $display("FAIL b2b_done: got done=%0b pass=%0b err=%0d, want 1 1 0",
               bus_a.done, bus_a.pass, bus_a.err_count);
    else n_pass++;
    // Restart from DONE with a faulty gate after a clean run.
    mode_a = 2;
    pulse_start_a();
    n_total++;
    if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0 || bus_a.err_count !== 3'd0 ||
        bus_a.first_fail_vld !== 1'b0 || bus_a.pass !== 1'b0)
      $display("FAIL b2b_restart: got busy=%0b done=%0b err=%0d vld=%0b pass=%0b, want 1 0 0 0 0",
               bus_a.busy, bus_a.done, bus_a.err_count, bus_a.first_fail_vld, bus_a.pass);
    else n_pass++;
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus_a.done !== 1'b1 || bus_a.err_count !== 3'd3 || bus_a.first_fail_vld !== 1'b1 ||
        bus_a.first_fail_vec !== 2'b00 || bus_a.pass !== 1'b0)
      $display("FAIL b2b_rerun: got done=%0b err=%0d vld=%0b vec=%0h pass=%0b, want 1 3 1 0 0",
               bus_a.done, bus_a.err_count, bus_a.first_fail_vld, bus_a.first_fail_vec, bus_a.pass);
    else n_pass++;
  endtask

  task automatic test_settle0();
    logic [7:0] ev;
    res_t       er;
    mode_b = 0;
    for (int k = 0; k < 8; k++) q_stim.push_back(k[7:0]);
    q_res.push_back(model_run(3, 0));
    pulse_start_b();
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e % 2 == 1) begin
        ev = q_stim.pop_front();
        n_total++;
        if (bus_b.stim !== ev[2:0] || bus_b.busy !== 1'b1)
          $display("FAIL s0_stim edge=%0d: got stim=%0h busy=%0b, want stim=%0h busy=1",
                   e, bus_b.stim, bus_b.busy, ev[2:0]);
        else n_pass++;
      end
      if (e == 15) begin
        n_total++;
        if (bus_b.done !== 1'b0)
          $display("FAIL s0_early_done: got done=%0b, want 0", bus_b.done);
        else n_pass++;
      end
    end
    er = q_res.pop_front();
    n_total++;
    if (bus_b.done !== 1'b1 || bus_b.pass !== er.pass || bus_b.err_count !== er.err[3:0] ||
        bus_b.first_fail_vld !== er.vld)
      $display("FAIL s0_result: got done=%0b pass=%0b err=%0d vld=%0b, want 1 %0b %0d %0b",
               bus_b.done, bus_b.pass, bus_b.err_count, bus_b.first_fail_vld, er.pass, er.err, er.vld);
    else n_pass++;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    mode_a      = 0;
    mode_b      = 0;
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    test_reset();
    test_run_modes();
    test_reset_midrun();
    test_back_to_back();
    test_settle0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
